// File: rtl/sdu_uart_tx.sv
// sdu_uart_tx: FIFO-buffered 8N1 UART transmitter for the serial debug unit.
// Bytes queue in a circular FIFO; the FSM drains them back-to-back onto txd.
module sdu_uart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    din,
    input  logic                          din_vld,
    output logic                          din_rdy,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shifter;
    logic            txd_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            bit_end, fifo_empty, push, pop;

    assign bit_end    = baud_cnt == BW'(DIV - 1);
    assign fifo_empty = fifo_cnt == '0;
    assign din_rdy    = fifo_cnt < (AW + 1)'(FIFO_DEPTH);
    assign push       = din_vld && din_rdy;
    assign pop        = !fifo_empty && (state == IDLE || (state == STOP && bit_end));
    assign busy       = state != IDLE || !fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
        end else begin
            state    <= state_nxt;
            txd      <= txd_nxt;
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            bit_idx  <= (state == DATA) ? (bit_end ? bit_idx + 1'b1 : bit_idx) : '0;
            // shifter[0] always holds the bit currently (or next) on the line
            if (pop) shifter <= mem[rd_ptr];
            else if (state == DATA && bit_end) shifter <= shifter >> 1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = START;
            START: if (bit_end) state_nxt = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end) state_nxt = fifo_empty ? IDLE : START;
        endcase
    end

    always_comb begin
        txd_nxt = txd;
        case (state)
            IDLE:  txd_nxt = fifo_empty;
            START: if (bit_end) txd_nxt = shifter[0];
            DATA:  if (bit_end) txd_nxt = (bit_idx == 3'd7) ? 1'b1 : shifter[1];
            STOP:  if (bit_end) txd_nxt = fifo_empty;
        endcase
    end
endmodule

// File: tb/tb_sdu_uart_tx.sv
// tb_sdu_uart_tx: directed bench for sdu_uart_tx at DIV=8 with a line decoder.
module tb_sdu_uart_tx;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy, txd, busy;
    logic [4:0] fifo_cnt;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;

    sdu_uart_tx #(.CLK_FREQ(8000000), .BAUD(1000000), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld),
        .din_rdy(din_rdy), .txd(txd), .busy(busy), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    // Line decoder: samples mid-bit, 4 then 8 clocks after each step.
    initial begin
        forever begin
            @(negedge txd);
            repeat (4) @(posedge clk);
            #1;
            if (txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(posedge clk);
                    #1;
                    rx_byte[i] = txd;
                end
                repeat (8) @(posedge clk);
                #1;
                if (txd == 1'b1) rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_txd(input logic [7:0] b, input int c);
        return (c <= 8) ? 1'b0 : (c <= 72) ? b[(c - 9) / 8] : 1'b1;
    endfunction

    task automatic test_reset();
        int lows = 0;
        rstn = 1'b0;
        din_vld = 1'b0;
        din = 8'h00;
        repeat (3) tick();
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", din_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (100) begin
            tick();
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL reset_idle_line: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_single();
        din = 8'hA5;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        checks++; if (fifo_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt_e0: got %0d expected 1", fifo_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b expected 1", busy); end
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL single_cnt_e1: got %0d expected 0", fifo_cnt); end
            end
            checks++; if (txd !== exp_txd(8'hA5, c)) begin errors++; $display("FAIL single_txd c=%0d: got %b expected %b", c, txd, exp_txd(8'hA5, c)); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e80: got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_e81: got %b expected 0", busy); end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_txd_e81: got %b expected 1", txd); end
    endtask

    task automatic test_back_to_back();
        logic e;
        din = 8'h00;
        din_vld = 1'b1;
        tick();
        din = 8'hFF;
        for (int c = 1; c <= 160; c++) begin
            tick();
            if (c == 1) din_vld = 1'b0;
            e = (c <= 80) ? exp_txd(8'h00, c) : exp_txd(8'hFF, c - 80);
            checks++; if (txd !== e) begin errors++; $display("FAIL b2b_txd c=%0d: got %b expected %b", c, txd, e); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e160: got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_e161: got %b expected 0", busy); end
    endtask

    task automatic test_full_fifo();
        int acc = 0;
        int n = 0;
        logic rdy;
        rx_q.delete();
        din = 8'h00;
        din_vld = 1'b1;
        for (int e = 0; e <= 82; e++) begin
            rdy = din_rdy;
            tick();
            if (rdy) begin
                acc++;
                din = din + 8'h01;
            end
            if (e == 16) begin
                checks++; if (acc !== 17) begin errors++; $display("FAIL full_accepted_e16: got %0d expected 17", acc); end
                checks++; if (din_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_e16: got %b expected 0", din_rdy); end
                checks++; if (fifo_cnt !== 5'd16) begin errors++; $display("FAIL full_cnt_e16: got %0d expected 16", fifo_cnt); end
            end
            if (e == 80) begin
                checks++; if (din_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_e80: got %b expected 0", din_rdy); end
            end
            if (e == 81) begin
                checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_e81: got %b expected 1", din_rdy); end
                checks++; if (fifo_cnt !== 5'd15) begin errors++; $display("FAIL full_cnt_e81: got %0d expected 15", fifo_cnt); end
            end
        end
        din_vld = 1'b0;
        checks++; if (acc !== 18) begin errors++; $display("FAIL full_accepted_e82: got %0d expected 18", acc); end
        while (busy && n < 2000) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain: busy=%b after %0d cycles expected 0", busy, n); end
        repeat (10) tick();
        checks++; if (rx_q.size() !== 18) begin errors++; $display("FAIL full_rx_count: got %0d expected 18", rx_q.size()); end
        for (int i = 0; i < 18 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL full_rx[%0d]: got %02h expected %02h", i, rx_q[i], 8'(i)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows = 0;
        din = 8'h3C;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        repeat (35) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_bit3: got %b expected 1", txd); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_txd: got %b expected 1", txd); end
        checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", fifo_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b expected 1", din_rdy); end
        repeat (2) tick();
        @(negedge clk);
        rstn = 1'b1;
        repeat (100) begin
            tick();
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d low cycles expected 0", lows); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_pointer_wrap();
        int n = 0;
        int cyc = 0;
        int over = 0;
        int w = 0;
        logic rdy;
        rx_q.delete();
        while (n < 40 && cyc < 10000) begin
            din = 8'(n);
            din_vld = ($urandom_range(0, 3) != 0);
            rdy = din_rdy;
            tick();
            cyc++;
            if (din_vld && rdy) n++;
            if (fifo_cnt > 5'd16) over++;
        end
        din_vld = 1'b0;
        checks++; if (n !== 40) begin errors++; $display("FAIL wrap_pushed: got %0d expected 40", n); end
        while (busy && w < 2000) begin
            tick();
            w++;
            if (fifo_cnt > 5'd16) over++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_drain: busy=%b after %0d cycles expected 0", busy, w); end
        checks++; if (over !== 0) begin errors++; $display("FAIL wrap_cnt_limit: got %0d overflows expected 0", over); end
        repeat (10) tick();
        checks++; if (rx_q.size() !== 40) begin errors++; $display("FAIL wrap_rx_count: got %0d expected 40", rx_q.size()); end
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL wrap_rx[%0d]: got %02h expected %02h", i, rx_q[i], 8'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_pointer_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
